// File: rtl/proc_pkg.sv
// Shared definitions for the processor's data-memory responder: FSM encoding,
// default data-segment base address and the wait-state ceiling.
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_ADDR       = 32'h1001_0000;
  localparam int unsigned DMEM_MAX_WAIT_STATES = 15;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with per-byte write enables and a registered read
// port that can be cleared (error responses) and is reset to zero.
module dmem_array
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic          clr_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read register holds the last read response until the next read or error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'h0000_0000;
    end else if (clr_i) begin
      rdata_q <= 32'h0000_0000;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Data-memory responder with a fixed wait-state latency and one-cycle dReady.
// Optional byte strobes: define DATA_MEMORY_BYTE_STROBE_EN to add dByteEn.
module data_memory
  import proc_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
`ifdef DATA_MEMORY_BYTE_STROBE_EN
  input  logic [3:0]  dByteEn,
`endif
  output logic [31:0] dReadData,
  output logic        dReady,
  output logic        dError
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN   = 32'(4 * DEPTH_WORDS);
  localparam int unsigned WS_EFF = (WAIT_STATES > DMEM_MAX_WAIT_STATES) ? DMEM_MAX_WAIT_STATES : WAIT_STATES;
  localparam logic [3:0]  WAIT_LOAD = 4'((WS_EFF > 0) ? WS_EFF - 1 : 0);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        write_q, both_q, ready_q, error_q;
  logic [3:0]  be_q;

  logic [31:0] src_addr_s, src_wdata_s, offset_s;
  logic        src_write_s, src_both_s, src_err_s, addr_ok_s;
  logic [3:0]  src_be_s, mem_we_s;
  logic        any_req_s, enter_resp_s, mem_re_s, mem_clr_s;
  logic [AW-1:0] word_idx_s;

  assign any_req_s = MemRead | MemWrite;

  // With zero wait states the array is accessed on the sampling edge itself, so
  // the live request is used in IDLE and the captured copy everywhere else.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_addr_s  = dAddress;
      src_wdata_s = dWriteData;
      src_write_s = MemWrite;
      src_both_s  = MemRead & MemWrite;
`ifdef DATA_MEMORY_BYTE_STROBE_EN
      src_be_s    = dByteEn;
`else
      src_be_s    = 4'hF;
`endif
    end else begin
      src_addr_s  = addr_q;
      src_wdata_s = wdata_q;
      src_write_s = write_q;
      src_both_s  = both_q;
      src_be_s    = be_q;
    end
  end

  assign offset_s   = src_addr_s - BASE_ADDR;
  assign addr_ok_s  = (offset_s[1:0] == 2'b00) && (offset_s < SPAN);
  assign src_err_s  = src_both_s | ~addr_ok_s;
  assign word_idx_s = offset_s[AW+1:2];

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          if (WS_EFF > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
            cnt_d   = 4'd0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign enter_resp_s = (state_d == ST_RESP) && (state_q != ST_RESP);

  // Array strobes: writes and reads happen only on the RESP entry edge.
  always_comb begin
    mem_we_s  = 4'h0;
    mem_re_s  = 1'b0;
    mem_clr_s = 1'b0;
    if (enter_resp_s) begin
      mem_clr_s = src_err_s;
      mem_re_s  = ~src_err_s & ~src_write_s;
      if (src_write_s && !src_err_s) begin
        mem_we_s = src_be_s;
      end else begin
        mem_we_s = 4'h0;
      end
    end else begin
      mem_we_s = 4'h0;
    end
  end

  // FSM state, counter and registered response flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= enter_resp_s;
      error_q <= enter_resp_s & src_err_s;
    end
  end

  // Request capture; only sampled while IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      write_q <= 1'b0;
      both_q  <= 1'b0;
      be_q    <= 4'h0;
    end else if ((state_q == ST_IDLE) && any_req_s) begin
      addr_q  <= dAddress;
      wdata_q <= dWriteData;
      write_q <= MemWrite;
      both_q  <= MemRead & MemWrite;
      be_q    <= src_be_s;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i  (clk),
    .rst_ni (rst),
    .re_i   (mem_re_s),
    .clr_i  (mem_clr_s),
    .we_i   (mem_we_s),
    .addr_i (word_idx_s),
    .wdata_i(src_wdata_s),
    .rdata_o(dReadData)
  );

  assign dReady = ready_q;
  assign dError = error_q;

endmodule
